// File: rtl/copro_alu_scheduler.sv
// Issue/result sequencer in front of the fixed-latency coprocessor ALU.
// Credit-tracks launched ops so every ALU result fits in the result FIFO.

package cvxif_instr_pkg;
  typedef enum logic [3:0] {
    ILLEGAL    = 4'h0,
    NOP        = 4'h1,
    ADD        = 4'h2,
    DOUBLE_RS1 = 4'h3,
    DOUBLE_RS2 = 4'h4,
    ADD_MULTI  = 4'h5,
    ADD_RS3_R  = 4'h6,
    ADD_RS3_R4 = 4'h7
  } opcode_t;
endpackage

module copro_alu_scheduler #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 4,
  parameter type hartid_t        = logic,
  parameter type id_t            = logic,
  parameter type registers_t     = logic,
  parameter type opcode_t        = cvxif_instr_pkg::opcode_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  opcode_t                    issue_opcode_i,
  input  registers_t                 issue_registers_i,
  input  hartid_t                    issue_hartid_i,
  input  id_t                        issue_id_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       flush_i,
  output opcode_t                    alu_opcode_o,
  output registers_t                 alu_registers_o,
  output hartid_t                    alu_hartid_o,
  output id_t                        alu_id_o,
  output logic [4:0]                 alu_rd_o,
  input  logic [XLEN-1:0]            alu_result_i,
  input  hartid_t                    alu_hartid_i,
  input  id_t                        alu_id_i,
  input  logic [4:0]                 alu_rd_i,
  input  logic                       alu_valid_i,
  input  logic                       alu_we_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [XLEN-1:0]            result_data_o,
  output hartid_t                    result_hartid_o,
  output id_t                        result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH+1)-1:0] inflight_o,
  output logic                       err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] data;
    hartid_t         hartid;
    id_t             id;
    logic [4:0]      rd;
    logic            we;
  } entry_t;

  logic [LATENCY-1:0] r_shadow, w_shadow_nxt;
  entry_t             r_mem [DEPTH];
  entry_t             w_head;
  logic [PTR_W-1:0]   r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [CNT_W-1:0]   r_inflight, w_inflight_nxt;
  logic [CNT_W-1:0]   w_shadow_ones, w_occ;
  logic               r_valid, w_valid_nxt;
  logic               r_err, w_err_nxt;
  logic               w_fire, w_pop, w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ALU samples its operands every cycle; the shadow pipe decides what counts.
  assign alu_opcode_o    = issue_opcode_i;
  assign alu_registers_o = issue_registers_i;
  assign alu_hartid_o    = issue_hartid_i;
  assign alu_id_o        = issue_id_i;
  assign alu_rd_o        = issue_rd_i;

  // Credit check: FIFO entries plus ops still inside the ALU.
  always_comb begin
    w_shadow_ones = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      w_shadow_ones = w_shadow_ones + CNT_W'(r_shadow[i]);
    end
    w_occ         = r_count + w_shadow_ones;
    w_pop         = r_valid & result_ready_i;
    issue_ready_o = ~flush_i & ((w_occ - CNT_W'(w_pop)) < CNT_W'(DEPTH));
    w_fire        = issue_valid_i & issue_ready_o;
    w_push        = r_shadow[LATENCY-1] & ~flush_i & alu_valid_i;
  end

  always_comb begin
    w_shadow_nxt = '0;
    w_count_nxt  = '0;
    w_wptr_nxt   = '0;
    w_rptr_nxt   = '0;
    w_err_nxt    = 1'b0;
    if (!flush_i) begin
      w_shadow_nxt    = r_shadow << 1;
      w_shadow_nxt[0] = w_fire;
      w_count_nxt     = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      w_wptr_nxt      = w_push ? ptr_inc(r_wptr) : r_wptr;
      w_rptr_nxt      = w_pop ? ptr_inc(r_rptr) : r_rptr;
      // Tap was set but the ALU rejected the opcode.
      w_err_nxt       = r_shadow[LATENCY-1] & ~alu_valid_i;
    end
    w_valid_nxt    = (w_count_nxt != '0);
    w_inflight_nxt = w_count_nxt;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      w_inflight_nxt = w_inflight_nxt + CNT_W'(w_shadow_nxt[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_shadow   <= w_shadow_nxt;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_count_nxt;
      r_inflight <= w_inflight_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Result storage; contents only matter where the count says they are live.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{data:   alu_result_i,
                         hartid: alu_hartid_i,
                         id:     alu_id_i,
                         rd:     alu_rd_i,
                         we:     alu_we_i};
    end
  end

  assign w_head          = r_valid ? r_mem[r_rptr] : entry_t'('0);
  assign result_valid_o  = r_valid;
  assign result_data_o   = w_head.data;
  assign result_hartid_o = w_head.hartid;
  assign result_id_o     = w_head.id;
  assign result_rd_o     = w_head.rd;
  assign result_we_o     = w_head.we;
  assign inflight_o      = r_inflight;
  assign err_o           = r_err;

endmodule

// File: tb/tb_copro_alu_scheduler.sv
// Directed bench for copro_alu_scheduler with a one-cycle ALU model (LATENCY=1, DEPTH=4).
module tb_copro_alu_scheduler;
  import cvxif_instr_pkg::*;

  typedef logic [1:0]        hartid_t;
  typedef logic [3:0]        id_t;
  typedef logic [1:0][31:0]  regs_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  opcode_t     issue_opcode_i = NOP;
  regs_t       issue_registers_i = '0;
  hartid_t     issue_hartid_i = '0;
  id_t         issue_id_i = '0;
  logic [4:0]  issue_rd_i = '0;
  logic        flush_i = 1'b0;
  opcode_t     alu_opcode_o;
  regs_t       alu_registers_o;
  hartid_t     alu_hartid_o;
  id_t         alu_id_o;
  logic [4:0]  alu_rd_o;
  logic [31:0] alu_result_i = '0;
  hartid_t     alu_hartid_i = '0;
  id_t         alu_id_i = '0;
  logic [4:0]  alu_rd_i = '0;
  logic        alu_valid_i = 1'b0;
  logic        alu_we_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [31:0] result_data_o;
  hartid_t     result_hartid_o;
  id_t         result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [2:0]  inflight_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  copro_alu_scheduler #(
    .XLEN(32), .LATENCY(1), .DEPTH(4),
    .hartid_t(hartid_t), .id_t(id_t), .registers_t(regs_t)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_opcode_i(issue_opcode_i), .issue_registers_i(issue_registers_i),
    .issue_hartid_i(issue_hartid_i), .issue_id_i(issue_id_i), .issue_rd_i(issue_rd_i),
    .flush_i(flush_i),
    .alu_opcode_o(alu_opcode_o), .alu_registers_o(alu_registers_o),
    .alu_hartid_o(alu_hartid_o), .alu_id_o(alu_id_o), .alu_rd_o(alu_rd_o),
    .alu_result_i(alu_result_i), .alu_hartid_i(alu_hartid_i), .alu_id_i(alu_id_i),
    .alu_rd_i(alu_rd_i), .alu_valid_i(alu_valid_i), .alu_we_i(alu_we_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_data_o(result_data_o), .result_hartid_o(result_hartid_o),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // One-cycle ALU: registers its operands every cycle, ILLEGAL gives no valid.
  always_ff @(posedge clk_i) begin
    alu_hartid_i <= alu_hartid_o;
    alu_id_i     <= alu_id_o;
    alu_rd_i     <= alu_rd_o;
    case (alu_opcode_o)
      ADD: begin
        alu_result_i <= alu_registers_o[0] + alu_registers_o[1];
        alu_valid_i  <= 1'b1;
        alu_we_i     <= 1'b1;
      end
      DOUBLE_RS1: begin
        alu_result_i <= alu_registers_o[0] + alu_registers_o[0];
        alu_valid_i  <= 1'b1;
        alu_we_i     <= 1'b1;
      end
      default: begin
        alu_result_i <= '0;
        alu_valid_i  <= 1'b0;
        alu_we_i     <= 1'b0;
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input opcode_t op, input logic [31:0] rs1,
                       input logic [31:0] rs2, input id_t id, input logic [4:0] rd,
                       input hartid_t hart);
    issue_valid_i     = v;
    issue_opcode_i    = op;
    issue_registers_i = {rs2, rs1};
    issue_id_i        = id;
    issue_rd_i        = rd;
    issue_hartid_i    = hart;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    next_cycle();
    next_cycle();
    check("rst_valid", 64'(result_valid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_inflight", 64'(inflight_o), 64'd0);
    check("rst_data", 64'(result_data_o), 64'd0);
    check("rst_rd", 64'(result_rd_o), 64'd0);
    rst_ni = 1'b1;
    next_cycle();

    // Single ADD: fire at cycle 0, result visible at cycle 2
    drive(1'b1, ADD, 32'd5, 32'd7, 4'd0, 5'd3, 2'd2);
    #1;
    check("t1_ready", 64'(issue_ready_o), 64'd1);
    next_cycle();
    drive(1'b0, NOP, 32'd0, 32'd0, 4'd0, 5'd0, 2'd0);
    #1;
    check("t1_c1_valid", 64'(result_valid_o), 64'd0);
    check("t1_c1_inflight", 64'(inflight_o), 64'd1);
    next_cycle();
    result_ready_i = 1'b1;
    #1;
    check("t1_c2_valid", 64'(result_valid_o), 64'd1);
    check("t1_c2_data", 64'(result_data_o), 64'd12);
    check("t1_c2_rd", 64'(result_rd_o), 64'd3);
    check("t1_c2_we", 64'(result_we_o), 64'd1);
    check("t1_c2_hart", 64'(result_hartid_o), 64'd2);
    check("t1_c2_inflight", 64'(inflight_o), 64'd1);
    next_cycle();
    check("t1_c3_valid", 64'(result_valid_o), 64'd0);
    check("t1_c3_inflight", 64'(inflight_o), 64'd0);

    // 8 back-to-back ops with the consumer always ready
    begin
      int exp_id = 0;
      for (int c = 0; c < 12; c++) begin
        if (c < 8) drive(1'b1, ADD, 32'(c), 32'd100, id_t'(c), 5'd1, 2'd0);
        else       drive(1'b0, NOP, 32'd0, 32'd0, 4'd0, 5'd0, 2'd0);
        #1;
        if (c < 8) check("t2_ready", 64'(issue_ready_o), 64'd1);
        check("t2_valid", 64'(result_valid_o), 64'((c >= 2) && (c <= 9)));
        if (result_valid_o) begin
          check("t2_id", 64'(result_id_o), 64'(exp_id));
          check("t2_data", 64'(result_data_o), 64'(exp_id + 100));
          exp_id++;
        end
        next_cycle();
      end
      check("t2_count", 64'(exp_id), 64'd8);
    end

    // Backpressure: offer 6 ops with consumer stalled, only 4 fit
    result_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, ADD, 32'(10 * c), 32'd1, id_t'(c), 5'd4, 2'd1);
      #1;
      check("t3_ready", 64'(issue_ready_o), 64'(c < 4));
      next_cycle();
    end
    check("t3_inflight_full", 64'(inflight_o), 64'd4);

    // Full FIFO, pop and issue in the same cycle, then drain in order
    drive(1'b1, ADD, 32'd40, 32'd1, 4'd4, 5'd4, 2'd1);
    result_ready_i = 1'b1;
    #1;
    check("t4_ready_pop_credit", 64'(issue_ready_o), 64'd1);
    for (int j = 0; j < 5; j++) begin
      check("t4_valid", 64'(result_valid_o), 64'd1);
      check("t4_id", 64'(result_id_o), 64'(j));
      check("t4_data", 64'(result_data_o), 64'(10 * j + 1));
      next_cycle();
      if (j == 0) begin
        drive(1'b0, NOP, 32'd0, 32'd0, 4'd0, 5'd0, 2'd0);
        check("t4_inflight_stays", 64'(inflight_o), 64'd4);
      end
      #1;
    end
    check("t4_drained", 64'(result_valid_o), 64'd0);
    check("t4_inflight_zero", 64'(inflight_o), 64'd0);

    // Flush with 2 buffered and 1 in flight
    result_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, ADD, 32'd1, 32'(c), id_t'(8 + c), 5'd5, 2'd0);
      next_cycle();
    end
    drive(1'b1, ADD, 32'd9, 32'd9, 4'd11, 5'd5, 2'd0);
    flush_i = 1'b1;
    #1;
    check("t5_pre_inflight", 64'(inflight_o), 64'd3);
    check("t5_flush_ready", 64'(issue_ready_o), 64'd0);
    next_cycle();
    flush_i = 1'b0;
    drive(1'b0, NOP, 32'd0, 32'd0, 4'd0, 5'd0, 2'd0);
    #1;
    check("t5_valid", 64'(result_valid_o), 64'd0);
    check("t5_inflight", 64'(inflight_o), 64'd0);
    check("t5_err", 64'(err_o), 64'd0);
    next_cycle();
    check("t5_late_valid", 64'(result_valid_o), 64'd0);
    check("t5_late_err", 64'(err_o), 64'd0);

    // Unsupported opcode: no result, one-cycle err pulse
    result_ready_i = 1'b1;
    drive(1'b1, ILLEGAL, 32'd3, 32'd3, 4'd12, 5'd6, 2'd0);
    #1;
    check("t6_ready", 64'(issue_ready_o), 64'd1);
    next_cycle();
    drive(1'b0, NOP, 32'd0, 32'd0, 4'd0, 5'd0, 2'd0);
    #1;
    check("t6_c1_inflight", 64'(inflight_o), 64'd1);
    check("t6_c1_err", 64'(err_o), 64'd0);
    next_cycle();
    check("t6_c2_err", 64'(err_o), 64'd1);
    check("t6_c2_valid", 64'(result_valid_o), 64'd0);
    check("t6_c2_inflight", 64'(inflight_o), 64'd0);
    next_cycle();
    check("t6_c3_err", 64'(err_o), 64'd0);

    // DOUBLE_RS1 result, then async reset mid-stream
    result_ready_i = 1'b0;
    drive(1'b1, DOUBLE_RS1, 32'd21, 32'd0, 4'd13, 5'd7, 2'd3);
    next_cycle();
    drive(1'b1, ADD, 32'd2, 32'd2, 4'd14, 5'd8, 2'd0);
    next_cycle();
    drive(1'b0, NOP, 32'd0, 32'd0, 4'd0, 5'd0, 2'd0);
    #1;
    check("t7_valid", 64'(result_valid_o), 64'd1);
    check("t7_data", 64'(result_data_o), 64'd42);
    check("t7_id", 64'(result_id_o), 64'd13);
    check("t7_inflight", 64'(inflight_o), 64'd2);
    #1;
    rst_ni = 1'b0;
    #1;
    check("t7_rst_valid", 64'(result_valid_o), 64'd0);
    check("t7_rst_inflight", 64'(inflight_o), 64'd0);
    check("t7_rst_err", 64'(err_o), 64'd0);
    check("t7_rst_data", 64'(result_data_o), 64'd0);
    check("t7_rst_id", 64'(result_id_o), 64'd0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/copro_alu_scheduler.md
Name: copro_alu_scheduler

Overview:
- Issue/result sequencer in front of the coprocessor ALU (copro_alu) in the CV-X-IF example coprocessor.
- Accepts issue requests over valid/ready and launches them into the fixed-latency ALU pipeline.
- Tracks in-flight operations in a shadow valid pipe, then buffers ALU results in a result FIFO that drains under result_ready_i backpressure.
- Credit-based issue stall guarantees no ALU result is ever dropped; flush_i kills in-flight and buffered work.

Parameters:
- XLEN, 32, result width.
- LATENCY, 1, ALU cycles from operand launch to result output (>=1); must match the ALU build.
- DEPTH, 4, result FIFO entries (>=2, any integer, not necessarily a power of 2).
- hartid_t, logic, hart id type.
- id_t, logic, instruction id type.
- registers_t, logic, source register bundle type.
- opcode_t, cvxif_instr_pkg::opcode_t, ALU opcode type.

Ports:
- clk_i in 1 clock.
- rst_ni in 1 asynchronous active-low reset.
- issue_valid_i in 1 issue request valid.
- issue_ready_o out 1 issue accepted when high together with issue_valid_i.
- issue_opcode_i in opcode_t opcode.
- issue_registers_i in registers_t source operands.
- issue_hartid_i in hartid_t hart id.
- issue_id_i in id_t instruction id.
- issue_rd_i in 5 destination register.
- flush_i in 1 synchronous kill of all in-flight and buffered work.
- alu_opcode_o out opcode_t ALU opcode.
- alu_registers_o out registers_t ALU operands.
- alu_hartid_o out hartid_t hart id to ALU.
- alu_id_o out id_t instruction id to ALU.
- alu_rd_o out 5 rd to ALU.
- alu_result_i in XLEN ALU result.
- alu_hartid_i in hartid_t ALU hart id.
- alu_id_i in id_t ALU instruction id.
- alu_rd_i in 5 ALU rd.
- alu_valid_i in 1 ALU result valid.
- alu_we_i in 1 ALU write enable.
- result_valid_o out 1 FIFO head valid.
- result_ready_i in 1 consumer ready.
- result_data_o out XLEN head result.
- result_hartid_o out hartid_t head hart id.
- result_id_o out id_t head instruction id.
- result_rd_o out 5 head rd.
- result_we_o out 1 head write enable.
- inflight_o out $clog2(DEPTH+1) in-flight plus buffered entries.
- err_o out 1 one-cycle pulse: expected ALU result missing.

Behaviour:
- Reset (async assert, sync deassert):
  - shadow pipe, FIFO pointers and counts cleared.
  - result_valid_o=0, err_o=0, inflight_o=0.
  - result_* payload outputs read 0.
- Fire condition: fire = issue_valid_i & issue_ready_o.
- ALU operand drive: alu_* outputs are combinational passthroughs of issue_* every cycle. The ALU registers them unconditionally, so the scheduler ignores ALU output on cycles it did not fire.
- Shadow pipe: LATENCY-bit shift register; bit0 <= fire & ~flush_i.
- Capture: when the shadow tap at LATENCY is 1 (cycle fire+LATENCY) and flush_i=0:
  - alu_valid_i=1: push {alu_result_i, hartid, id, rd, we} into the FIFO.
  - alu_valid_i=0 (unsupported opcode): no push; err_o pulses the next cycle.
  - Either way, the credit is released.
- Pop: pop = result_valid_o & result_ready_i. Head advances the next cycle. Payload is held stable while result_valid_o=1 and result_ready_i=0.
- Credits: occ = FIFO count + shadow ones, where occ <= DEPTH always.
  - issue_ready_o = ~flush_i & ((occ - pop) < DEPTH), combinational.
  - inflight_o = occ, registered view.
- Throughput: 1 op/cycle sustained while result_ready_i=1 and DEPTH > LATENCY.
- Minimum latency: issue fire at cycle t gives result_valid_o=1 at cycle t+LATENCY+1 (one FIFO write cycle).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO: visible the next cycle; no bypass.
- Pointer wrap: modulo DEPTH; full/empty decided by the count, not by the pointers.
- Ordering: results leave in issue order (fixed latency, single FIFO).
- flush_i=1 in cycle t:
  - FIFO emptied and shadow pipe zeroed at the t edge.
  - Any capture or fire in cycle t is discarded; issue_ready_o=0 in cycle t.
  - result_valid_o=0 from t+1.
  - Killed ALU outputs arriving later are ignored, with no err_o.
- Flush and pop in the same cycle: the pop is accepted by the consumer; the FIFO is still emptied.

Test Plan:
- LATENCY=1, DEPTH=4, ADD rs1=5 rs2=7 rd=3 fired cycle 0 -> result_valid_o=1 at cycle 2, data=12, rd=3, we=1, inflight_o=1 then 0 after the pop.
- 8 back-to-back ops, result_ready_i=1 -> issue_ready_o never drops; results leave in id order 0..7, one per cycle.
- result_ready_i=0, issue 6 ops -> exactly 4 accepted, issue_ready_o=0 afterwards; raise ready -> 4 results with ids 0..3 and values intact, then issue resumes.
- FIFO full with ready=1 and valid issue in the same cycle -> issue_ready_o=1 (pop credit); count stays 4.
- 2 ops buffered, 1 in flight, flush_i pulse -> result_valid_o=0 next cycle, inflight_o=0, the in-flight ALU output is not pushed, err_o=0.
- Unsupported opcode issued (alu_valid_i=0 at the tap) -> no result produced, err_o one-cycle pulse, inflight_o returns to 0; reset asserted mid-stream -> all outputs 0 immediately.
